fifo_synchronous_param: RTL



---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_sync_ram.sv | 32 +++
 rtl/fifo_synchronous_param.sv | 92 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers and parameter legality checks for the synchronous FIFO family
package fifo_pkg;

    function automatic int depth_of(input int pointer_width);
        return 1 << pointer_width;
    endfunction

    function automatic int count_width(input int pointer_width);
        return pointer_width + 1;
    endfunction

    function automatic bit params_ok(input int data_width, input int pointer_width,
                                     input int almost_full_th, input int almost_empty_th);
        return data_width >= 1 && pointer_width >= 1 &&
               almost_full_th >= 1 && almost_full_th <= depth_of(pointer_width) &&
               almost_empty_th >= 0 && almost_empty_th <= depth_of(pointer_width) - 1;
    endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// fifo_sync_ram: dual-port storage array with synchronous write and registered synchronous read
module fifo_sync_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int POINTER_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [POINTER_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    input  logic [POINTER_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);
    localparam int DEPTH = depth_of(POINTER_WIDTH);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // storage is never reset; a write to the slot being read lands after the read samples it
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // read register holds its value between accepted reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fifo_synchronous_param.sv
// fifo_synchronous_param: single-clock FIFO with count, thresholds and optional sticky error flags (FIFO_ERROR_FLAG_EN)
module fifo_synchronous_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int POINTER_WIDTH   = 3,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 1
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef FIFO_ERROR_FLAG_EN
    input  logic                     err_clr,
    output logic                     fifo_overflow,
    output logic                     fifo_underflow,
`endif
    input  logic                     store,
    input  logic                     load,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic [POINTER_WIDTH:0]   fifo_count,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     fifo_almost_full,
    output logic                     fifo_almost_empty
);
    localparam int PW = POINTER_WIDTH;
    localparam logic [PW:0] AF_TH = ALMOST_FULL_TH[PW:0];
    localparam logic [PW:0] AE_TH = ALMOST_EMPTY_TH[PW:0];

    if (!params_ok(DATA_WIDTH, POINTER_WIDTH, ALMOST_FULL_TH, ALMOST_EMPTY_TH)) begin : g_bad_params
        $error("fifo_synchronous_param: illegal parameter combination");
    end

    logic          wr_acc, rd_acc;
    logic [PW:0]   w_ptr, r_ptr, w_next, r_next, count_next;

    assign wr_acc     = store & (!fifo_full | load);
    assign rd_acc     = load & !fifo_empty;
    assign w_next     = w_ptr + {{PW{1'b0}}, wr_acc};
    assign r_next     = r_ptr + {{PW{1'b0}}, rd_acc};
    assign count_next = fifo_count + {{PW{1'b0}}, wr_acc} - {{PW{1'b0}}, rd_acc};

    fifo_sync_ram #(
        .DATA_WIDTH   (DATA_WIDTH),
        .POINTER_WIDTH(POINTER_WIDTH)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_acc),
        .wr_addr(w_ptr[PW-1:0]),
        .wr_data(data_in),
        .rd_en  (rd_acc),
        .rd_addr(r_ptr[PW-1:0]),
        .rd_data(data_out)
    );

    // pointers, occupancy and flags all registered from their post-edge values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr             <= '0;
            r_ptr             <= '0;
            fifo_count        <= '0;
            fifo_full         <= 1'b0;
            fifo_empty        <= 1'b1;
            fifo_almost_full  <= 1'b0;
            fifo_almost_empty <= 1'b1;
        end else begin
            w_ptr             <= w_next;
            r_ptr             <= r_next;
            fifo_count        <= count_next;
            fifo_full         <= (w_next[PW-1:0] == r_next[PW-1:0]) && (w_next[PW] != r_next[PW]);
            fifo_empty        <= w_next == r_next;
            fifo_almost_full  <= count_next >= AF_TH;
            fifo_almost_empty <= count_next <= AE_TH;
        end
    end

`ifdef FIFO_ERROR_FLAG_EN
    // sticky error flags; a fresh rejection outranks a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_overflow  <= 1'b0;
            fifo_underflow <= 1'b0;
        end else begin
            fifo_overflow  <= (store & !wr_acc) | (fifo_overflow & !err_clr);
            fifo_underflow <= (load & !rd_acc) | (fifo_underflow & !err_clr);
        end
    end
`endif

endmodule
